// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter
//   Iterative AES SubBytes engine. A 128-bit state is accepted on an
//   in_valid/in_ready handshake. LANES bytes are substituted per clock
//   through the FIPS-197 S-box, and the result is presented on a held
//   out_valid/out_ready handshake.
//
//   Optional feature macro: SUBBYTES_INV_EN
//     When defined, this adds the 'inv' port. inv=1, sampled on the accept
//     edge, selects the inverse S-box for the whole state in flight.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_state is valid
//   in_ready   block can accept a state (IDLE only)
//   in_state   state to substitute, byte k = in_state[127-8k -: 8]
//   out_valid  out_state holds a completed result (DONE only)
//   out_ready  downstream accepts the result
//   out_state  substituted state, same byte ordering as in_state
//   inv        (SUBBYTES_INV_EN only) select inverse S-box
module sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
`ifdef SUBBYTES_INV_EN
   ,
   input  logic         inv
`endif
);

   localparam int N  = 16 / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_p0;
   state_t          state_nxt;
   logic [CW-1:0]   count_p0;
   logic [127:0]    work_p0;
   logic [127:0]    work_nxt;
   logic [127:0]    res_p1;
   logic            accept;
   logic            last;
`ifdef SUBBYTES_INV_EN
   logic            inv_mode_p0;
`endif

   // GF(2^8) arithmetic over the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      gf_mul = p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0), built from an addition
   // chain: 254 = 240 + 12 + 2.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      gf_inv = gf_mul(gf_mul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      rotl8 = (b << k) | (b >> (8 - k));
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      logic [7:0] v;
      v = gf_inv(b);
      sbox_fwd = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

`ifdef SUBBYTES_INV_EN
   function automatic logic [7:0] sbox_inv(input logic [7:0] b);
      sbox_inv = gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
   endfunction
`endif

   function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic use_inv);
`ifdef SUBBYTES_INV_EN
      sub_byte = use_inv ? sbox_inv(b) : sbox_fwd(b);
`else
      sub_byte = sbox_fwd(b) ^ {8{use_inv & 1'b0}};
`endif
   endfunction

   assign accept = (state_p0 == IDLE) && in_valid;
   assign last   = (state_p0 == BUSY) && (count_p0 == LAST);

   // Stage p0: LANES S-boxes replace the byte group selected by the counter.
   always_comb begin
      int   idx;
      logic mode;
      idx      = 0;
`ifdef SUBBYTES_INV_EN
      mode     = inv_mode_p0;
`else
      mode     = 1'b0;
`endif
      work_nxt = work_p0;
      for (int l = 0; l < LANES; l++) begin
         idx = int'(count_p0) * LANES + l;
         work_nxt[127 - 8*idx -: 8] = sub_byte(work_p0[127 - 8*idx -: 8], mode);
      end
   end

   // State register and control.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_p0 <= IDLE;
         count_p0 <= '0;
         res_p1   <= '0;
`ifdef SUBBYTES_INV_EN
         inv_mode_p0 <= 1'b0;
`endif
      end else begin
         state_p0 <= state_nxt;
         if (accept)
            count_p0 <= '0;
         else if ((state_p0 == BUSY) && !last)
            count_p0 <= count_p0 + CW'(1);
         // Result register only changes on completion, so out_state keeps
         // the previous result through IDLE and BUSY.
         if (last)
            res_p1 <= work_nxt;
`ifdef SUBBYTES_INV_EN
         if (accept)
            inv_mode_p0 <= inv;
`endif
      end
   end

   // Work register carries data only; it is always reloaded on accept.
   always_ff @(posedge clk) begin
      if (accept)
         work_p0 <= in_state;
      else if (state_p0 == BUSY)
         work_p0 <= work_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         IDLE:    if (in_valid)  state_nxt = BUSY;
         BUSY:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Outputs decode the registered state only, so they do not depend
   // combinationally on in_valid or out_ready.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_p0)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   assign out_state = res_p1;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb_sub_bytes_iter
//   Directed bench for sub_bytes_iter. Five instances (LANES = 1, 2, 4, 8, 16)
//   share all inputs, so each vector exercises every lane count at once.
//   Instance g has LANES = 1<<g and N = 16>>g.
module tb_sub_bytes_iter;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic [127:0] in_state;
   logic         out_ready;
   logic         ir [5];
   logic         ov [5];
   logic [127:0] os [5];
`ifdef SUBBYTES_INV_EN
   logic         inv;
`endif

   int n_checks;
   int n_fail;

   localparam logic [127:0] ZERO16   = 128'h0;
   localparam logic [127:0] ALL63    = {16{8'h63}};
   localparam logic [127:0] ALLFF    = {16{8'hff}};
   localparam logic [127:0] ALL16    = {16{8'h16}};
   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SEQ_OUT  = 128'h637c777bf26b6fc53001672bfed7ab76;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      sub_bytes_iter #(.LANES(1 << g)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (in_valid),
         .in_ready  (ir[g]),
         .in_state  (in_state),
         .out_valid (ov[g]),
         .out_ready (out_ready),
         .out_state (os[g])
`ifdef SUBBYTES_INV_EN
         ,
         .inv       (inv)
`endif
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check handshake outputs and, once valid, the data of every instance.
   task automatic check_all(input string name, input int c, input logic [127:0] exp);
      for (int i = 0; i < 5; i++) begin
         logic ev;
         ev = (c >= (16 >> i));
         n_checks++;
         if (ov[i] !== ev) begin
            n_fail++;
            $display("FAIL %s lanes=%0d cycle=%0d out_valid=%b expected=%b", name, 1 << i, c, ov[i], ev);
         end
         n_checks++;
         if (ir[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s lanes=%0d cycle=%0d in_ready=%b expected=0", name, 1 << i, c, ir[i]);
         end
         if (ev) begin
            n_checks++;
            if (os[i] !== exp) begin
               n_fail++;
               $display("FAIL %s lanes=%0d cycle=%0d out_state=%h expected=%h", name, 1 << i, c, os[i], exp);
            end
         end
      end
   endtask

   task automatic check_idle(input string name, input logic [127:0] exp_os, input bit chk_os);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (ov[i] !== 1'b0 || ir[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s lanes=%0d out_valid=%b in_ready=%b expected 0/1", name, 1 << i, ov[i], ir[i]);
         end
         if (chk_os) begin
            n_checks++;
            if (os[i] !== exp_os) begin
               n_fail++;
               $display("FAIL %s lanes=%0d out_state=%h expected=%h", name, 1 << i, os[i], exp_os);
            end
         end
      end
   endtask

   // mode: 0 plain, 1 drive new data on in_valid while busy, 2 flip inv after accept.
   // last_cycle: how long to hold out_ready low (>= 16 so every instance completes).
   task automatic run_vec(input string name, input logic [127:0] din, input logic [127:0] exp,
                          input int mode, input int last_cycle);
      in_valid = 1'b1;
      in_state = din;
      tick();                           // accept edge = cycle 0
      in_valid = 1'b0;
      in_state = ~din;
`ifdef SUBBYTES_INV_EN
      if (mode == 2) inv = ~inv;
`endif
      for (int c = 1; c <= last_cycle; c++) begin
         if (mode == 1 && c <= 2) begin
            in_valid = 1'b1;
            in_state = 128'h0123456789abcdeffedcba9876543210;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         check_all(name, c, exp);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_idle({name, "_release"}, exp, 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      check_idle("reset", ZERO16, 1'b1);
      reset = 1'b0;
      tick();
      check_idle("reset_idle", ZERO16, 1'b1);
   endtask

   task automatic test_zero();
      run_vec("zero", ZERO16, ALL63, 0, 16);
   endtask

   task automatic test_fips();
      run_vec("fips", FIPS_IN, FIPS_OUT, 0, 16);
   endtask

   task automatic test_backpressure();
      run_vec("backpressure", SEQ_IN, SEQ_OUT, 0, 26);
   endtask

   task automatic test_busy_stall();
      run_vec("busy_stall", FIPS_IN, FIPS_OUT, 1, 16);
   endtask

   task automatic test_mid_reset();
      in_valid = 1'b1;
      in_state = ZERO16;
      tick();                           // accept edge
      in_valid = 1'b0;
      tick();                           // now in second BUSY cycle
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("mid_reset", ZERO16, 1'b1);
      run_vec("after_reset", ALLFF, ALL16, 0, 16);
   endtask

   task automatic test_back_to_back();
      run_vec("b2b_a", SEQ_IN, SEQ_OUT, 0, 16);
      run_vec("b2b_b", FIPS_IN, FIPS_OUT, 0, 16);
   endtask

`ifdef SUBBYTES_INV_EN
   task automatic test_inv();
      inv = 1'b1;
      run_vec("inv_63", ALL63, ZERO16, 2, 16);   // inv flips to 0 while busy
      inv = 1'b1;
      run_vec("inv_00", ZERO16, {16{8'h52}}, 0, 16);
      inv = 1'b0;
      run_vec("fwd_after_inv", ZERO16, ALL63, 2, 16);  // inv flips to 1 while busy
      inv = 1'b0;
   endtask
`endif

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_state  = '0;
      out_ready = 1'b0;
`ifdef SUBBYTES_INV_EN
      inv       = 1'b0;
`endif
      #1;
      test_reset();
      test_zero();
      test_fips();
      test_backpressure();
      test_busy_stall();
      test_mid_reset();
      test_back_to_back();
`ifdef SUBBYTES_INV_EN
      test_inv();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative AES SubBytes engine for the encryption datapath, the forward counterpart of the decryption-side inverse substitution. Accepts one 128-bit state per valid/ready handshake and substitutes `LANES` bytes per clock through the forward AES S-box (FIPS-197). It then presents the substituted state on a held output handshake. It sits between AddRoundKey and ShiftRows in the AES-256 encryption round loop and trades S-box area for latency.

## Interface

**Parameters**
- `LANES`, 4, bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is a compile-time error. `N = 16/LANES` is the number of substitution cycles.

**Ports**
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_state` is valid.
- `in_ready`  output  1  block can accept a state.
- `in_state`  input  128  state to substitute. Byte k (k=0..15) is `in_state[127-8k -: 8]`.
- `out_valid`  output  1  `out_state` holds a completed result.
- `out_ready`  input  1  downstream accepts the result.
- `out_state`  output  128  substituted state, same byte ordering as `in_state`.
- `inv`  input  1  only present with `SUBBYTES_INV_EN`; selects the inverse S-box.

## Operation

**Internal registers**
- 128-bit work register.
- Cycle counter, `$clog2(N)` bits; minimum 1 bit.
- 2-bit state: IDLE, BUSY, DONE.

**IDLE**
- `in_ready=1`, `out_valid=0`.
- On `in_valid & in_ready`: load `in_state` into the work register, clear the counter, go to BUSY.

**BUSY**
- `in_ready=0`, `out_valid=0`.
- Each cycle, replace bytes `count*LANES .. count*LANES+LANES-1` of the work register with S(byte), using `LANES` parallel S-box instances.
- Increment the counter. After the substitution with `count==N-1`, go to DONE.
- Inputs are ignored while BUSY.

**DONE**
- `out_valid=1`, `out_state`=work register, held stable until the handshake completes.
- On `out_valid & out_ready`: go to IDLE.
- No same-cycle accept of a new input in DONE.

**Boundary conditions**
- `LANES=16`: `N=1`, a single BUSY cycle.
- The counter wraps to 0 only via the IDLE load. It never exceeds N-1.
- `out_state` is held at the last result while in IDLE or BUSY. It is meaningful only when `out_valid=1`.
- Reset asserted in any state: the next state is IDLE and any in-flight state is discarded.

**Arithmetic**
- No arithmetic on data; pure byte substitution.
- The counter is compared against the constant N-1.

## Timing

**Reset values**
- `in_ready=1`, `out_valid=0`, `out_state=128'h0`.
- Internal state IDLE, counter 0.

**Latency**
- Accept edge at cycle 0. `out_valid` rises after edge N, i.e. it is visible in cycle N.
- Example: `LANES=4` gives `out_valid` in cycle 4.

**Throughput**
- One state per N+2 cycles at best: accept, N BUSY cycles, DONE handshake, return to IDLE.
- With `out_ready` tied high: IDLE → BUSY×N → DONE (1 cycle) → IDLE.

**Handshake rules**
- `in_ready` and `out_valid` are registered. Neither depends combinationally on `in_valid` or `out_ready`.
- `out_state` does not change while `out_valid=1` and `out_ready=0`.
- Reset takes precedence over every handshake in the same cycle.

## Configuration

**`SUBBYTES_INV_EN` defined**
- Adds the `inv` port and `LANES` inverse S-box instances.
- `inv` is sampled and registered on the accept edge. Later changes do not affect the state in flight.
- `inv=1` substitutes through the inverse S-box, so the block also serves decryption rounds.
- Reset clears the registered mode to 0.

**`SUBBYTES_INV_EN` undefined**
- No `inv` port and no inverse S-box logic.
- Forward substitution only.

## Test plan

- **Reset, LANES=4:** hold `reset` for 2 cycles → `in_ready=1`, `out_valid=0`, `out_state=0`. Then send an all-zero state → `out_state` = sixteen bytes of 0x63, `out_valid` high exactly in cycle 4.
- **FIPS-197 round-1 vector:** `in_state=193de3bea0f4e22b9ac68d2ae9f84808` → `out_state=d42711aee0bf98f1b8b45de51e415230`. Repeat for `LANES`=1, 2, 4, 8, 16 with `out_valid` in cycles 16, 8, 4, 2, 1.
- **Backpressure:** `in_state=000102…0f` with `out_ready=0` for 10 cycles → `out_state=637c777bf26b6fc53001672bfed7ab76` held stable, `in_ready=0`. Then assert `out_ready` for 1 cycle → `out_valid` drops and `in_ready` returns next cycle.
- **Busy stall:** while BUSY, toggle `in_valid` with new data → ignored; the result matches the first accepted state only.
- **Mid-operation reset:** assert `reset` in the second BUSY cycle → next cycle IDLE, `out_valid=0`, `out_state=0`. A following all-0xff input yields all 0x16.
- **With `SUBBYTES_INV_EN`:** `inv=1`, `in_state` of all 0x63 → all 0x00. `inv=1`, all 0x00 → all 0x52. Toggle `inv` during BUSY → no effect on the result.
